// File: rtl/decode_issue_ctrl.sv
// Decode/issue stage controller: holds one fetched instruction, presents it to the
// decoder, checks the integer scoreboard and issues over a valid/ready handshake.

package decode_issue_pkg;

    typedef enum logic [2:0] {
        INVALID   = 3'd0,
        OP_ADD    = 3'd1,
        OP_ADDI   = 3'd2,
        OP_STORE  = 3'd3,
        OP_LOAD   = 3'd4,
        OP_BRANCH = 3'd5
    } funct_t;

    typedef struct packed {
        funct_t      funct;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
    } decoded_instr_t;

endpackage

module decode_issue_ctrl
    import decode_issue_pkg::*;
#(
    parameter int unsigned XLEN        = 64,
    parameter int unsigned STALL_CNT_W = 32
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   flush_i,
    input  logic [31:0]            instr_i,
    input  logic [XLEN-1:0]        pc_i,
    input  logic                   instr_valid_i,
    output logic                   instr_ready_o,
    output logic [31:0]            code_o,
    input  decoded_instr_t         cmd_i,
    output decoded_instr_t         issue_cmd_o,
    output logic [XLEN-1:0]        issue_pc_o,
    output logic                   issue_valid_o,
    input  logic                   issue_ready_i,
    input  logic                   wb_valid_i,
    input  logic [4:0]             wb_rd_i,
    output logic                   illegal_o,
    output logic [31:0]            sb_busy_o,
    output logic [STALL_CNT_W-1:0] stall_cnt_o
);

    localparam logic [1:0] EMPTY   = 2'd0;
    localparam logic [1:0] HOLD    = 2'd1;
    localparam logic [1:0] ILLEGAL = 2'd2;

    logic [1:0]             state_q, state_d;
    logic [31:0]            instr_q;
    logic [XLEN-1:0]        pc_q;
    logic [31:0]            sb_q, sb_d;
    logic [STALL_CNT_W-1:0] stall_cnt_q;

    logic in_hold;
    logic is_invalid;
    logic hazard;
    logic fire;
    logic accept;

    assign in_hold    = (state_q == HOLD);
    assign is_invalid = (cmd_i.funct == INVALID);
    // Conservative: rs2 is checked even for formats that never read it.
    assign hazard     = sb_q[cmd_i.rs1] | sb_q[cmd_i.rs2];

    assign issue_valid_o = rst_ni & in_hold & ~is_invalid & ~hazard & ~flush_i;
    assign fire          = issue_valid_o & issue_ready_i;
    assign instr_ready_o = rst_ni & ~flush_i & ((state_q == EMPTY) | (in_hold & fire));
    assign accept        = instr_valid_i & instr_ready_o;
    assign illegal_o     = rst_ni & (state_q == ILLEGAL);

    assign code_o      = instr_q;
    assign issue_cmd_o = cmd_i;
    assign issue_pc_o  = pc_q;
    assign sb_busy_o   = sb_q;
    assign stall_cnt_o = stall_cnt_q;

    always_comb begin
        state_d = state_q;
        if (flush_i) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY:   if (accept) state_d = HOLD;
                HOLD: begin
                    if (is_invalid)  state_d = ILLEGAL;
                    else if (fire)   state_d = accept ? HOLD : EMPTY;
                end
                ILLEGAL: state_d = ILLEGAL;
                default: state_d = EMPTY;
            endcase
        end
    end

    // Set is applied after clear so an issue wins over a same-cycle writeback.
    always_comb begin
        sb_d = sb_q;
        if (wb_valid_i && (wb_rd_i != 5'd0)) sb_d[wb_rd_i] = 1'b0;
        if (fire && (cmd_i.rd != 5'd0))      sb_d[cmd_i.rd] = 1'b1;
        sb_d[0] = 1'b0;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= EMPTY;
            instr_q     <= '0;
            pc_q        <= '0;
            sb_q        <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            sb_q    <= sb_d;
            if (accept) begin
                instr_q <= instr_i;
                pc_q    <= pc_i;
            end
            if (in_hold && hazard && !flush_i && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_decode_issue_ctrl.sv
// Self-checking bench for decode_issue_ctrl: a slot-level reference model checked every
// cycle, plus directed vectors with hand-computed literal expectations.

module tb_decode_issue_ctrl;
    import decode_issue_pkg::*;

    localparam int unsigned XLEN = 64;
    localparam int unsigned SW   = 4;

    logic            clk;
    logic            rst_ni;
    logic            flush_i;
    logic [31:0]     instr_i;
    logic [XLEN-1:0] pc_i;
    logic            instr_valid_i;
    logic            instr_ready_o;
    logic [31:0]     code_o;
    decoded_instr_t  cmd_i;
    decoded_instr_t  issue_cmd_o;
    logic [XLEN-1:0] issue_pc_o;
    logic            issue_valid_o;
    logic            issue_ready_i;
    logic            wb_valid_i;
    logic [4:0]      wb_rd_i;
    logic            illegal_o;
    logic [31:0]     sb_busy_o;
    logic [SW-1:0]   stall_cnt_o;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    decode_issue_ctrl #(.XLEN(XLEN), .STALL_CNT_W(SW)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .flush_i(flush_i),
        .instr_i(instr_i), .pc_i(pc_i), .instr_valid_i(instr_valid_i),
        .instr_ready_o(instr_ready_o), .code_o(code_o), .cmd_i(cmd_i),
        .issue_cmd_o(issue_cmd_o), .issue_pc_o(issue_pc_o),
        .issue_valid_o(issue_valid_o), .issue_ready_i(issue_ready_i),
        .wb_valid_i(wb_valid_i), .wb_rd_i(wb_rd_i), .illegal_o(illegal_o),
        .sb_busy_o(sb_busy_o), .stall_cnt_o(stall_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Small RV32 subset decoder standing in for the real combinational decoder.
    function automatic decoded_instr_t dec(input logic [31:0] w);
        decoded_instr_t d;
        d.funct = INVALID;
        d.rd    = w[11:7];
        d.rs1   = w[19:15];
        d.rs2   = w[24:20];
        d.imm   = {{20{w[31]}}, w[31:20]};
        case (w[6:0])
            7'h13: if (w[14:12] == 3'd0) d.funct = OP_ADDI;
            7'h33: if (w[14:12] == 3'd0 && w[31:25] == 7'd0) d.funct = OP_ADD;
            7'h23: begin
                d.funct = OP_STORE;
                d.imm   = {{20{w[31]}}, w[31:25], w[11:7]};
                d.rd    = 5'd0;
            end
            default: ;
        endcase
        if (d.funct == INVALID) d.rd = 5'd0;
        return d;
    endfunction

    always_comb cmd_i = dec(code_o);

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: an instruction slot that is empty, holding, or stuck illegal.
    bit              m_full;
    bit              m_bad;
    logic [31:0]     m_word;
    logic [XLEN-1:0] m_pc;
    bit [31:0]       m_sb;
    int unsigned     m_stall;

    initial begin
        m_full = 0; m_bad = 0; m_word = '0; m_pc = '0; m_sb = '0; m_stall = 0;
    end

    always @(negedge clk) begin
        decoded_instr_t c;
        bit waiting, blocked, e_valid, e_fire, e_ready;
        c       = dec(m_word);
        waiting = m_full && !m_bad;
        blocked = m_sb[c.rs1] || m_sb[c.rs2];
        e_valid = rst_ni && waiting && c.funct != INVALID && !blocked && !flush_i;
        e_fire  = e_valid && issue_ready_i;
        e_ready = rst_ni && !flush_i && (!m_full || e_fire);

        check("instr_ready", 64'(instr_ready_o), 64'(e_ready));
        check("issue_valid", 64'(issue_valid_o), 64'(e_valid));
        check("illegal",     64'(illegal_o),     64'(rst_ni && m_bad));
        check("sb_busy",     64'(sb_busy_o),     64'(m_sb));
        check("stall_cnt",   64'(stall_cnt_o),   64'(m_stall));
        if (rst_ni) check("code", 64'(code_o), 64'(m_word));
        if (e_valid) begin
            check("issue_pc",  64'(issue_pc_o),  64'(m_pc));
            check("issue_cmd", 64'(issue_cmd_o), 64'(c));
        end

        if (!rst_ni) begin
            m_full = 0; m_bad = 0; m_word = '0; m_pc = '0; m_sb = '0; m_stall = 0;
        end else begin
            if (wb_valid_i && wb_rd_i != 0) m_sb[wb_rd_i] = 1'b0;
            if (e_fire && c.rd != 0)        m_sb[c.rd]    = 1'b1;
            if (waiting && blocked && !flush_i && m_stall < (2**SW - 1)) m_stall++;
            if (flush_i) begin
                m_full = 0; m_bad = 0;
            end else if (waiting && c.funct == INVALID) begin
                m_bad = 1;
            end else if (e_ready && instr_valid_i) begin
                m_full = 1; m_word = instr_i; m_pc = pc_i;
            end else if (e_fire) begin
                m_full = 0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_ni = 0; flush_i = 0; instr_i = '0; pc_i = '0; instr_valid_i = 0;
        issue_ready_i = 0; wb_valid_i = 0; wb_rd_i = '0;
        at_neg(); step();
        at_neg(); step();

        // Reset release and idle
        rst_ni = 1;
        at_neg();
        check("lit_reset_ready", 64'(instr_ready_o), 64'd1);
        check("lit_reset_valid", 64'(issue_valid_o), 64'd0);
        check("lit_reset_sb",    64'(sb_busy_o),     64'd0);
        check("lit_reset_stall", 64'(stall_cnt_o),   64'd0);
        step();

        // Back-to-back ADDI x1,x0,5 then ADDI x2,x0,7
        issue_ready_i = 1; instr_valid_i = 1; instr_i = 32'h00500093; pc_i = 64'h100;
        at_neg(); step();
        instr_i = 32'h00700113; pc_i = 64'h104;
        at_neg();
        check("lit_b2b_valid0", 64'(issue_valid_o), 64'd1);
        check("lit_b2b_pc0",    issue_pc_o,          64'h100);
        check("lit_b2b_ready0", 64'(instr_ready_o), 64'd1);
        step();
        instr_valid_i = 0;
        at_neg();
        check("lit_b2b_valid1", 64'(issue_valid_o), 64'd1);
        check("lit_b2b_pc1",    issue_pc_o,          64'h104);
        step();

        // RAW hazard: ADD x3,x1,x2 stalls until x1 and x2 are written back
        instr_valid_i = 1; instr_i = 32'h002081B3; pc_i = 64'h108;
        at_neg();
        check("lit_b2b_sb", 64'(sb_busy_o), 64'h6);
        step();
        instr_valid_i = 0;
        for (int i = 0; i < 20; i++) begin
            at_neg();
            check("lit_raw_stalled", 64'(issue_valid_o), 64'd0);
            step();
        end
        wb_valid_i = 1; wb_rd_i = 5'd2;
        at_neg();
        check("lit_stall_sat", 64'(stall_cnt_o), 64'hF);
        step();
        wb_rd_i = 5'd1;
        at_neg();
        check("lit_no_bypass", 64'(issue_valid_o), 64'd0);
        step();
        wb_valid_i = 0;
        at_neg();
        check("lit_raw_issue", 64'(issue_valid_o), 64'd1);
        check("lit_raw_pc",    issue_pc_o,          64'h108);
        step();

        // Backpressure on ADDI x4,x0,1 while ADDI x6,x0,2 waits upstream
        issue_ready_i = 0; instr_valid_i = 1; instr_i = 32'h00100213; pc_i = 64'h200;
        at_neg();
        check("lit_raw_sb", 64'(sb_busy_o), 64'h8);
        step();
        instr_i = 32'h00200313; pc_i = 64'h204;
        for (int i = 0; i < 3; i++) begin
            at_neg();
            check("lit_bp_valid", 64'(issue_valid_o), 64'd1);
            check("lit_bp_ready", 64'(instr_ready_o), 64'd0);
            check("lit_bp_pc",    issue_pc_o,          64'h200);
            step();
        end
        issue_ready_i = 1;
        at_neg(); step();
        instr_valid_i = 0;
        at_neg();
        check("lit_bp_pc_next", issue_pc_o,         64'h204);
        check("lit_bp_sb",      64'(sb_busy_o),     64'h18);
        step();

        // Illegal instruction, then flush with a dropped concurrent fetch
        instr_valid_i = 1; instr_i = 32'hFFFFFFFF; pc_i = 64'h300;
        at_neg(); step();
        instr_valid_i = 0;
        at_neg();
        check("lit_ill_noissue", 64'(issue_valid_o), 64'd0);
        step();
        at_neg();
        check("lit_ill_set", 64'(illegal_o), 64'd1);
        step();
        flush_i = 1; instr_valid_i = 1; instr_i = 32'h00000293; pc_i = 64'h3F0;
        at_neg();
        check("lit_flush_ready", 64'(instr_ready_o), 64'd0);
        step();
        flush_i = 0; instr_valid_i = 0;
        at_neg();
        check("lit_flush_ill", 64'(illegal_o), 64'd0);
        check("lit_flush_sb",  64'(sb_busy_o), 64'h58);
        step();

        // Set/clear collision on x5, then a store and a wb to x0
        instr_valid_i = 1; instr_i = 32'h00000293; pc_i = 64'h400;
        at_neg(); step();
        instr_valid_i = 0; wb_valid_i = 1; wb_rd_i = 5'd5;
        at_neg(); step();
        wb_valid_i = 0;
        at_neg();
        check("lit_collide_sb", 64'(sb_busy_o), 64'h78);
        step();
        instr_valid_i = 1; instr_i = 32'h00002023; pc_i = 64'h404; wb_valid_i = 1; wb_rd_i = 5'd0;
        at_neg(); step();
        instr_valid_i = 0;
        at_neg(); step();
        wb_valid_i = 0;
        at_neg();
        check("lit_store_sb", 64'(sb_busy_o), 64'h78);
        step();

        // Flush while stalled on a hazard (ADD x7,x3,x0)
        instr_valid_i = 1; instr_i = 32'h000183B3; pc_i = 64'h408;
        at_neg(); step();
        instr_valid_i = 0;
        at_neg(); step();
        flush_i = 1;
        at_neg(); step();
        flush_i = 0;
        at_neg();
        check("lit_flush2_ready", 64'(instr_ready_o), 64'd1);
        step();
        repeat (3) begin at_neg(); step(); end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
